// File: rtl/processing_unit.sv
// processing_unit: eight-register datapath with PC, IR, address register, ALU operand Y,
// zero flag Z and two combinational buses.
module processing_unit #(
  parameter int word_size = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_R0,
  input  logic                 load_R1,
  input  logic                 load_R2,
  input  logic                 load_R3,
  input  logic                 load_R4,
  input  logic                 load_R5,
  input  logic                 load_R6,
  input  logic                 load_R7,
  input  logic                 load_PC,
  input  logic                 inc_PC,
  input  logic [3:0]           sel_bus_1_MUX,
  input  logic [1:0]           sel_bus_2_MUX,
  input  logic                 load_IR,
  input  logic                 load_add_R,
  input  logic                 load_reg_Y,
  input  logic                 load_reg_Z,
  input  logic [word_size-1:0] mem_word,
  output logic [word_size-1:0] instruction,
  output logic [word_size-1:0] address,
  output logic [word_size-1:0] bus_1,
  output logic                 zero
);
  logic [word_size-1:0] r_q [8];
  logic [word_size-1:0] r_d [8];
  logic [word_size-1:0] pc_q, pc_d, ir_q, ir_d, ar_q, ar_d, y_q, y_d;
  logic                 z_q, z_d;
  logic [word_size-1:0] bus_2, alu_out;
  logic [4:0]           opcode;
  logic [7:0]           load_r;

  assign load_r = {load_R7, load_R6, load_R5, load_R4, load_R3, load_R2, load_R1, load_R0};
  assign opcode = ir_q[word_size-1 -: 5];

  assign bus_1 = !sel_bus_1_MUX[3] ? r_q[sel_bus_1_MUX[2:0]] :
                 sel_bus_1_MUX == 4'd8 ? pc_q : '0;

  assign bus_2 = sel_bus_2_MUX == 2'd0 ? alu_out :
                 sel_bus_2_MUX == 2'd1 ? bus_1 :
                 sel_bus_2_MUX == 2'd2 ? mem_word : '0;

  always_comb begin
    case (opcode)
      5'd1:    alu_out = y_q + bus_1;
      5'd2:    alu_out = y_q - bus_1;
      5'd3:    alu_out = y_q & bus_1;
      5'd4:    alu_out = ~bus_1;
      5'd5:    alu_out = y_q | bus_1;
      5'd6:    alu_out = y_q ^ bus_1;
      5'd7:    alu_out = ~(y_q ^ bus_1);
      5'd8:    alu_out = ~(y_q & bus_1);
      5'd9:    alu_out = ~(y_q | bus_1);
      default: alu_out = '0;
    endcase
  end

  // All next-state values derive from pre-edge register contents, so self-loads cannot loop.
  always_comb begin
    for (int k = 0; k < 8; k++) r_d[k] = load_r[k] ? bus_2 : r_q[k];
    pc_d = load_PC ? bus_2 : inc_PC ? pc_q + word_size'(1) : pc_q;
    ir_d = load_IR ? bus_2 : ir_q;
    ar_d = load_add_R ? bus_2 : ar_q;
    y_d  = load_reg_Y ? bus_2 : y_q;
    z_d  = load_reg_Z ? (alu_out == '0) : z_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q  <= '{default: '0};
      pc_q <= '0;
      ir_q <= '0;
      ar_q <= '0;
      y_q  <= '0;
      z_q  <= 1'b0;
    end else begin
      r_q  <= r_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ar_q <= ar_d;
      y_q  <= y_d;
      z_q  <= z_d;
    end
  end

  assign instruction = ir_q;
  assign address     = ar_q;
  assign zero        = z_q;
endmodule
